// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: pc-side encodings, reset
// address and the controller state encoding.
package pipe_ctrl_pkg;

   localparam int          INST_ADDR_WIDTH = 32;
   localparam logic [31:0] INI_INST_ADDR   = 32'h0;
   localparam logic        JUMP            = 1'b1;
   localparam logic        HOLD            = 1'b1;

   typedef enum logic [1:0] {
      CTRL_RUN   = 2'd0,
      CTRL_HOLD  = 2'd1,
      CTRL_FLUSH = 2'd2
   } ctrl_state_e;

   // Bits needed to hold values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Small load/clear counter: decrements toward zero (UP=0) or increments with
// saturation at LIMIT (UP=1). term_o flags that the count equals TERM.
module pipe_ctrl_cnt #(
   parameter int             W     = 3,
   parameter bit             UP    = 1'b0,
   parameter logic [W-1:0]   LIMIT = '1,
   parameter logic [W-1:0]   TERM  = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         term_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         if (UP) begin
            if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates EX redirects, divider busy and ID load-use
// hazards into registered jump/hold/flush controls for the pc and IF/ID stages.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int                ADDR_W       = INST_ADDR_WIDTH,
   parameter logic [ADDR_W-1:0] RESET_ADDR   = ADDR_W'(INI_INST_ADDR),
   parameter int                FLUSH_CYCLES = 2,
   parameter int                MAX_HOLD     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_req_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              busy_i,
   input  logic              load_use_i,
   output logic              jump_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              hold_o,
   output logic              flush_o,
   output logic              stall_id_o,
   output logic              hold_timeout_o
);

   localparam int FL_W = 3;
   localparam int WD_W = cnt_w(MAX_HOLD);

   ctrl_state_e       state_q, state_d;
   logic              jump_q, jump_d;
   logic              hold_q, hold_d;
   logic              flush_q, flush_d;
   logic              pend_q, pend_d;
   logic              timeout_q, timeout_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              fl_load, fl_en, fl_zero;
   logic              wd_last;

   always_comb begin
      state_d = state_q;
      jump_d  = 1'b0;
      hold_d  = 1'b0;
      flush_d = 1'b0;
      pend_d  = pend_q;
      addr_d  = addr_q;
      paddr_d = paddr_q;
      fl_load = 1'b0;
      fl_en   = 1'b0;
      case (state_q)
         CTRL_RUN: begin
            if (jump_req_i) begin
               jump_d  = JUMP;
               addr_d  = jump_addr_i;
               flush_d = 1'b1;
               fl_load = 1'b1;
               state_d = CTRL_FLUSH;
            end else if (busy_i) begin
               hold_d  = HOLD;
               state_d = CTRL_HOLD;
            end else if (load_use_i) begin
               hold_d  = HOLD;
            end
         end
         CTRL_HOLD: begin
            if (busy_i) begin
               hold_d = HOLD;
               // Only the first redirect seen while frozen is kept.
               if (jump_req_i && !pend_q) begin
                  pend_d  = 1'b1;
                  paddr_d = jump_addr_i;
               end
            end else if (pend_q || jump_req_i) begin
               jump_d  = JUMP;
               addr_d  = pend_q ? paddr_q : jump_addr_i;
               pend_d  = 1'b0;
               flush_d = 1'b1;
               fl_load = 1'b1;
               state_d = CTRL_FLUSH;
            end else begin
               if (load_use_i) hold_d = HOLD;
               state_d = CTRL_RUN;
            end
         end
         CTRL_FLUSH: begin
            // Redirects and load-use here come from the wrong path; busy waits.
            if (!fl_zero) begin
               flush_d = 1'b1;
               fl_en   = 1'b1;
            end else if (busy_i) begin
               hold_d  = HOLD;
               state_d = CTRL_HOLD;
            end else begin
               state_d = CTRL_RUN;
            end
         end
         default: state_d = CTRL_RUN;
      endcase
      timeout_d = timeout_q | (hold_d & wd_last);
   end

   pipe_ctrl_cnt #(
      .W(FL_W), .UP(1'b0), .LIMIT('1), .TERM('0)
   ) u_flush_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (1'b0),
      .load_i    (fl_load),
      .load_val_i(FL_W'(FLUSH_CYCLES - 1)),
      .en_i      (fl_en),
      .term_o    (fl_zero)
   );

   // Counts consecutive hold cycles; term flags the cycle before the limit.
   pipe_ctrl_cnt #(
      .W(WD_W), .UP(1'b1), .LIMIT(WD_W'(MAX_HOLD)), .TERM(WD_W'(MAX_HOLD - 1))
   ) u_wd_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (~hold_d),
      .load_i    (1'b0),
      .load_val_i('0),
      .en_i      (hold_d),
      .term_o    (wd_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CTRL_RUN;
         jump_q    <= 1'b0;
         hold_q    <= 1'b0;
         flush_q   <= 1'b0;
         pend_q    <= 1'b0;
         timeout_q <= 1'b0;
         addr_q    <= RESET_ADDR;
         paddr_q   <= RESET_ADDR;
      end else begin
         state_q   <= state_d;
         jump_q    <= jump_d;
         hold_q    <= hold_d;
         flush_q   <= flush_d;
         pend_q    <= pend_d;
         timeout_q <= timeout_d;
         addr_q    <= addr_d;
         paddr_q   <= paddr_d;
      end
   end

   assign jump_o         = jump_q;
   assign jump_addr_o    = addr_q;
   assign hold_o         = hold_q;
   assign stall_id_o     = hold_q;
   assign flush_o        = flush_q;
   assign hold_timeout_o = timeout_q;

endmodule
